rf_write_queue: RTL and testbench
=================================

Name: rf_write_queue

Overview:
- Writeback-side producer for the register file write port (reg_wr / wr_addr / wr_data).
- Collects results from the ALU and the load unit through valid/ready handshakes and buffers them in a DEPTH-entry in-order queue.
- Drains at most one write per cycle into the register file.
- Provides combinational bypass lookup for rs1/rs2, so decode reads stay coherent with writes still in flight.

Parameters:
- XLEN, 32, data width.
- AW, 5, register address width.
- DEPTH, 4, queue entries (power of 2, >=2).

Ports:
- clk  in  1  clock
- rst  in  1  reset (synchronous, active-high)
- alu_valid  in  1  ALU result valid
- alu_ready  out  1  ALU result accepted
- alu_rd  in  AW  ALU destination register
- alu_data  in  XLEN  ALU result
- ld_valid  in  1  load result valid
- ld_ready  out  1  load result accepted
- ld_rd  in  AW  load destination register
- ld_data  in  XLEN  load result
- hold  in  1  pause draining (register-file port busy/stall)
- reg_wr  out  1  register-file write enable
- wr_addr  out  AW  register-file write address
- wr_data  out  XLEN  register-file write data
- rs1_addr  in  AW  bypass lookup address 1
- rs2_addr  in  AW  bypass lookup address 2
- rs1_hit  out  1  rs1 pending in queue or output register
- rs1_fwd  out  XLEN  youngest pending value for rs1
- rs2_hit  out  1  rs2 pending
- rs2_fwd  out  XLEN  youngest pending value for rs2
- empty  out  1  queue and output register both idle

Behaviour:
- Reset (synchronous):
  - count=0, head/tail=0.
  - reg_wr=0, wr_addr=0, wr_data=0.
  - All queued entries are discarded, including on reset mid-operation.
  - empty=1; ready outputs follow from count=0.
- Ready rules use only the registered count (free = DEPTH-count). A same-cycle pop does not free a slot.
  - ld_ready = (free>=1).
  - alu_ready = (free>=2) when ld_valid and ld_rd!=0; otherwise (free>=1). The load wins a single free slot.
- Handshake:
  - A transfer occurs at the clock edge where valid&&ready.
  - rd==0 transfers are accepted but not stored (x0 writes are dropped).
  - Accepted data/rd is sampled at that edge.
- Ordering when both transfer in the same cycle: the load entry is enqueued first (older), then the ALU entry. Tail advances by 0, 1 or 2, mod DEPTH.
- Drain:
  - At each edge with count>0 (pre-edge) and hold=0, pop the head and register reg_wr=1, wr_addr=head.addr, wr_data=head.data.
  - Otherwise reg_wr=0 next cycle; wr_addr and wr_data hold their last values.
  - Entries enqueued at edge E are poppable at edge E+1 at the earliest.
  - Minimum latency from input handshake edge to reg_wr high is 1 cycle; reg_wr is high for exactly one cycle per entry.
- count update: count_next = count + pushes - pop. count never exceeds DEPTH and never underflows. Simultaneous push and pop is legal at any level.
- Pointer wrap: head and tail increment mod DEPTH.
- Bypass (combinational, per lookup port):
  - hit=0 when addr==0.
  - Search order, youngest first: queue entries from tail-1 back to head, then the output register (when reg_wr=1).
  - The first match supplies fwd. When hit=0, fwd=0.
  - Inputs not yet accepted are never forwarded.
- empty = (count==0) && !reg_wr.
- hold asserted with count=0 has no effect. hold does not block enqueue.

Decomposition:
- Package rf_wq_pkg holds:
  - XLEN and AW defaults.
  - typedef wb_entry_t {logic [AW-1:0] addr; logic [XLEN-1:0] data;}.
  - REG_ZERO constant (5'd0).
- One sub-module, rf_wq_bypass:
  - Priority match over the queue array plus the output register for one lookup address.
  - Instantiated twice (rs1, rs2).
- Queue storage, pointers and ready logic stay in the top module.

Test Plan:
- Reset mid-operation: 3 entries queued, pulse rst -> next cycle empty=1, reg_wr=0, rs1_hit=0 for all queued rds, alu_ready=1.
- Dual push: ld (rd=5, 0xAAAA0005) and alu (rd=6, 0x00000006) in the same cycle, queue empty -> reg_wr writes r5 next cycle, r6 the following cycle, in order.
- Full/priority: fill to 3 entries with hold=1, then ld_valid (rd=7) and alu_valid (rd=8) together -> ld_ready=1, alu_ready=0. Load accepted, count=4, then both readies low.
- x0 drop: alu_valid rd=0 data=0xDEADBEEF -> alu_ready=1, count unchanged, reg_wr never asserts, rs1_addr=0 gives rs1_hit=0.
- Bypass youngest-wins: enqueue r3=0x11 then r3=0x22 with hold=1 -> rs1_addr=3 gives hit=1 and fwd=0x22. Release hold -> after both drain, fwd=0x22 from the output register, then hit=0.
- Wrap-around: stream 10 ALU writes (rd=1..10, data=rd*0x100) with hold toggling every 3 cycles -> all 10 writes appear on reg_wr in order, count never >4, no reg_wr during hold-induced gaps.

Source files
------------

// File: rtl/rf_wq_pkg.sv
// Shared types and constants for the register-file write queue.
// Contents:
//   DEFAULT_XLEN / DEFAULT_AW - default data and register-address widths
//   wb_entry_t                - one pending writeback (destination + value)
//   REG_ZERO                  - architectural zero register index
package rf_wq_pkg;

  localparam int unsigned DEFAULT_XLEN = 32;
  localparam int unsigned DEFAULT_AW   = 5;

  typedef struct packed {
    logic [DEFAULT_AW-1:0]   addr;
    logic [DEFAULT_XLEN-1:0] data;
  } wb_entry_t;

  localparam logic [DEFAULT_AW-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/rf_wq_bypass.sv
// Bypass lookup for one decode read port. Finds the youngest pending write to
// lookup_addr among the queued entries and the register-file output register.
// Ports:
//   lookup_addr - register being read by decode
//   q_addr/q_data/q_valid - queue contents, index 0 = oldest, DEPTH-1 = youngest
//   out_valid/out_addr/out_data - output register (write being applied now)
//   hit - a pending write to lookup_addr exists (never for x0)
//   fwd - value of that write, 0 when hit=0
module rf_wq_bypass
  import rf_wq_pkg::*;
#(
  parameter int unsigned XLEN  = DEFAULT_XLEN,
  parameter int unsigned AW    = DEFAULT_AW,
  parameter int unsigned DEPTH = 4
) (
  input  logic [AW-1:0]              lookup_addr,
  input  logic [DEPTH-1:0][AW-1:0]   q_addr,
  input  logic [DEPTH-1:0][XLEN-1:0] q_data,
  input  logic [DEPTH-1:0]           q_valid,
  input  logic                       out_valid,
  input  logic [AW-1:0]              out_addr,
  input  logic [XLEN-1:0]            out_data,
  output logic                       hit,
  output logic [XLEN-1:0]            fwd
);

  // Scan oldest to youngest so the last match (the youngest) wins. The output
  // register is older than anything still queued, so it is considered first.
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    if (lookup_addr != AW'(REG_ZERO)) begin
      if (out_valid && (out_addr == lookup_addr)) begin
        hit = 1'b1;
        fwd = out_data;
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (q_valid[i] && (q_addr[i] == lookup_addr)) begin
          hit = 1'b1;
          fwd = q_data[i];
        end
      end
    end
  end

endmodule

// File: rtl/rf_write_queue.sv
// Writeback queue feeding the register-file write port. Accepts ALU and load
// results over valid/ready, buffers them in order in a DEPTH-entry queue and
// drains at most one per cycle into a registered write port. Provides
// combinational bypass for two decode read addresses.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   alu_valid/ready/rd/data       - ALU result handshake
//   ld_valid/ready/rd/data        - load result handshake
//   hold                          - stall draining (enqueue still allowed)
//   reg_wr/wr_addr/wr_data        - registered register-file write port
//   rs1_addr/hit/fwd, rs2_*       - bypass lookups
//   empty                         - nothing queued and no write in progress
module rf_write_queue
  import rf_wq_pkg::*;
#(
  parameter int unsigned XLEN  = DEFAULT_XLEN,
  parameter int unsigned AW    = DEFAULT_AW,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [AW-1:0]   ld_rd,
  input  logic [XLEN-1:0] ld_data,
  input  logic            hold,
  output logic            reg_wr,
  output logic [AW-1:0]   wr_addr,
  output logic [XLEN-1:0] wr_data,
  input  logic [AW-1:0]   rs1_addr,
  output logic            rs1_hit,
  output logic [XLEN-1:0] rs1_fwd,
  input  logic [AW-1:0]   rs2_addr,
  output logic            rs2_hit,
  output logic [XLEN-1:0] rs2_fwd,
  output logic            empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DEPTH-1:0][XLEN-1:0] mem_data_q, mem_data_d;
  logic [PW-1:0]              head_q, head_d;
  logic [PW-1:0]              tail_q, tail_d;
  logic [CW-1:0]              count_q, count_d;
  logic                       reg_wr_q, reg_wr_d;
  logic [AW-1:0]              wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]            wr_data_q, wr_data_d;

  logic [CW-1:0] free;
  logic          ld_nz, alu_nz;
  logic          ld_push, alu_push, pop;
  logic [PW-1:0] alu_slot;

  // Ready is derived from the registered count only; a pop in the same cycle
  // does not make room. A storable load claims a single free slot first.
  always_comb begin
    free      = CW'(DEPTH) - count_q;
    ld_nz     = (ld_rd != AW'(REG_ZERO));
    alu_nz    = (alu_rd != AW'(REG_ZERO));
    ld_ready  = (free >= CW'(1));
    alu_ready = (ld_valid && ld_nz) ? (free >= CW'(2)) : (free >= CW'(1));
    // x0 results complete the handshake but never occupy a slot.
    ld_push   = ld_valid && ld_ready && ld_nz;
    alu_push  = alu_valid && alu_ready && alu_nz;
    pop       = (count_q != '0) && !hold;
    alu_slot  = tail_q + PW'(ld_push);
  end

  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    if (ld_push) begin
      mem_addr_d[tail_q] = ld_rd;
      mem_data_d[tail_q] = ld_data;
    end
    if (alu_push) begin
      mem_addr_d[alu_slot] = alu_rd;
      mem_data_d[alu_slot] = alu_data;
    end
    tail_d  = tail_q + PW'(ld_push) + PW'(alu_push);
    head_d  = head_q + PW'(pop);
    count_d = count_q + CW'(ld_push) + CW'(alu_push) - CW'(pop);

    reg_wr_d  = pop;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (pop) begin
      wr_addr_d = mem_addr_q[head_q];
      wr_data_d = mem_data_q[head_q];
    end
  end

  // Storage needs no reset: count_q gates every read of it.
  always_ff @(posedge clk) begin
    mem_addr_q <= mem_addr_d;
    mem_data_q <= mem_data_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      reg_wr_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      reg_wr_q  <= reg_wr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign reg_wr  = reg_wr_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign empty   = (count_q == '0) && !reg_wr_q;

  // Present the queue to the bypass units in age order, oldest at index 0.
  logic [DEPTH-1:0][AW-1:0]   age_addr;
  logic [DEPTH-1:0][XLEN-1:0] age_data;
  logic [DEPTH-1:0]           age_valid;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_addr[i]  = mem_addr_q[head_q + PW'(i)];
      age_data[i]  = mem_data_q[head_q + PW'(i)];
      age_valid[i] = (CW'(i) < count_q);
    end
  end

  rf_wq_bypass #(
    .XLEN  (XLEN),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_bypass_rs1 (
    .lookup_addr (rs1_addr),
    .q_addr      (age_addr),
    .q_data      (age_data),
    .q_valid     (age_valid),
    .out_valid   (reg_wr_q),
    .out_addr    (wr_addr_q),
    .out_data    (wr_data_q),
    .hit         (rs1_hit),
    .fwd         (rs1_fwd)
  );

  rf_wq_bypass #(
    .XLEN  (XLEN),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_bypass_rs2 (
    .lookup_addr (rs2_addr),
    .q_addr      (age_addr),
    .q_data      (age_data),
    .q_valid     (age_valid),
    .out_valid   (reg_wr_q),
    .out_addr    (wr_addr_q),
    .out_data    (wr_data_q),
    .hit         (rs2_hit),
    .fwd         (rs2_fwd)
  );

endmodule

// File: tb/tb_rf_write_queue.sv
// Directed self-checking bench for rf_write_queue (XLEN=32, AW=5, DEPTH=4).
module tb_rf_write_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        hold;
  logic        reg_wr;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_hit, rs2_hit;
  logic [31:0] rs1_fwd, rs2_fwd;
  logic        empty;

  int checks   = 0;
  int failures = 0;

  rf_write_queue #(
    .XLEN  (32),
    .AW    (5),
    .DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .hold      (hold),
    .reg_wr    (reg_wr),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rs1_addr  (rs1_addr),
    .rs1_hit   (rs1_hit),
    .rs1_fwd   (rs1_fwd),
    .rs2_addr  (rs2_addr),
    .rs2_hit   (rs2_hit),
    .rs2_fwd   (rs2_fwd),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 1'b0;
    alu_rd    = '0;
    alu_data  = '0;
    ld_valid  = 1'b0;
    ld_rd     = '0;
    ld_data   = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, got, pending, pend_pre;
    logic acc, hold_prev, exp_pop;

    rst      = 1'b1;
    hold     = 1'b0;
    rs1_addr = '0;
    rs2_addr = '0;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    settle();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_reg_wr", 32'(reg_wr), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd1);
    chk("rst_alu_ready", 32'(alu_ready), 32'd1);

    // Dual push into an empty queue: load is older than the ALU result.
    ld_valid = 1'b1; ld_rd = 5'd5; ld_data = 32'hAAAA0005;
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h00000006;
    settle();
    chk("dual_ld_ready", 32'(ld_ready), 32'd1);
    chk("dual_alu_ready", 32'(alu_ready), 32'd1);
    tick();
    idle_inputs();
    rs1_addr = 5'd5;
    rs2_addr = 5'd6;
    settle();
    chk("dual_no_wr_yet", 32'(reg_wr), 32'd0);
    chk("dual_not_empty", 32'(empty), 32'd0);
    chk("dual_rs1_hit", 32'(rs1_hit), 32'd1);
    chk("dual_rs1_fwd", rs1_fwd, 32'hAAAA0005);
    chk("dual_rs2_fwd", rs2_fwd, 32'h00000006);
    tick();
    chk("dual_wr1", 32'(reg_wr), 32'd1);
    chk("dual_addr1", 32'(wr_addr), 32'd5);
    chk("dual_data1", wr_data, 32'hAAAA0005);
    tick();
    chk("dual_wr2", 32'(reg_wr), 32'd1);
    chk("dual_addr2", 32'(wr_addr), 32'd6);
    chk("dual_data2", wr_data, 32'h00000006);
    tick();
    chk("dual_wr_done", 32'(reg_wr), 32'd0);
    chk("dual_addr_held", 32'(wr_addr), 32'd6);
    chk("dual_empty", 32'(empty), 32'd1);

    // Reset with three entries queued.
    hold = 1'b1;
    ld_valid = 1'b1; ld_rd = 5'd9; ld_data = 32'h909;
    alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hA0A;
    tick();
    ld_valid = 1'b0;
    alu_rd = 5'd11; alu_data = 32'hB0B;
    tick();
    idle_inputs();
    rs1_addr = 5'd11;
    settle();
    chk("mid_pre_hit", 32'(rs1_hit), 32'd1);
    chk("mid_pre_fwd", rs1_fwd, 32'hB0B);
    chk("mid_pre_alu_ready", 32'(alu_ready), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    chk("mid_empty", 32'(empty), 32'd1);
    chk("mid_reg_wr", 32'(reg_wr), 32'd0);
    chk("mid_alu_ready", 32'(alu_ready), 32'd1);
    for (int r = 9; r <= 11; r++) begin
      rs1_addr = 5'(r);
      settle();
      chk("mid_rs1_hit", 32'(rs1_hit), 32'd0);
    end
    hold = 1'b0;
    tick();
    chk("mid_no_drain1", 32'(reg_wr), 32'd0);
    tick();
    chk("mid_no_drain2", 32'(reg_wr), 32'd0);

    // Fill to 3 under hold, then load and ALU compete for the last slot.
    hold = 1'b1;
    ld_valid = 1'b1; ld_rd = 5'd2; ld_data = 32'h200;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h300;
    tick();
    ld_valid = 1'b0;
    alu_rd = 5'd4; alu_data = 32'h400;
    tick();
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h700;
    alu_valid = 1'b1; alu_rd = 5'd8; alu_data = 32'h800;
    settle();
    chk("full_ld_ready", 32'(ld_ready), 32'd1);
    chk("full_alu_ready", 32'(alu_ready), 32'd0);
    tick();
    chk("full_ld_ready_after", 32'(ld_ready), 32'd0);
    chk("full_alu_ready_after", 32'(alu_ready), 32'd0);
    idle_inputs();
    rs1_addr = 5'd7;
    rs2_addr = 5'd8;
    settle();
    chk("full_rs1_hit", 32'(rs1_hit), 32'd1);
    chk("full_rs1_fwd", rs1_fwd, 32'h700);
    chk("full_rs2_miss", 32'(rs2_hit), 32'd0);
    chk("full_rs2_fwd0", rs2_fwd, 32'd0);
    chk("full_hold_no_wr", 32'(reg_wr), 32'd0);
    hold = 1'b0;
    tick();
    chk("full_d1_addr", 32'(wr_addr), 32'd2);
    chk("full_d1_data", wr_data, 32'h200);
    tick();
    chk("full_d2_addr", 32'(wr_addr), 32'd3);
    chk("full_d2_data", wr_data, 32'h300);
    tick();
    chk("full_d3_addr", 32'(wr_addr), 32'd4);
    chk("full_d3_data", wr_data, 32'h400);
    tick();
    chk("full_d4_wr", 32'(reg_wr), 32'd1);
    chk("full_d4_addr", 32'(wr_addr), 32'd7);
    chk("full_d4_data", wr_data, 32'h700);
    tick();
    chk("full_drained_wr", 32'(reg_wr), 32'd0);
    chk("full_drained_empty", 32'(empty), 32'd1);

    // x0 writes handshake but are dropped.
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEADBEEF;
    rs1_addr = 5'd0;
    settle();
    chk("x0_alu_ready", 32'(alu_ready), 32'd1);
    chk("x0_rs1_hit", 32'(rs1_hit), 32'd0);
    tick();
    idle_inputs();
    settle();
    chk("x0_empty", 32'(empty), 32'd1);
    tick();
    chk("x0_no_wr1", 32'(reg_wr), 32'd0);
    tick();
    chk("x0_no_wr2", 32'(reg_wr), 32'd0);

    // Two writes to r3: the younger value must win everywhere.
    hold = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
    tick();
    alu_data = 32'h22;
    tick();
    idle_inputs();
    rs1_addr = 5'd3;
    rs2_addr = 5'd3;
    settle();
    chk("byp_q_hit", 32'(rs1_hit), 32'd1);
    chk("byp_q_fwd", rs1_fwd, 32'h22);
    chk("byp_q_fwd2", rs2_fwd, 32'h22);
    hold = 1'b0;
    tick();
    chk("byp_d1_data", wr_data, 32'h11);
    chk("byp_d1_fwd", rs1_fwd, 32'h22);
    tick();
    chk("byp_out_hit", 32'(rs1_hit), 32'd1);
    chk("byp_out_fwd", rs1_fwd, 32'h22);
    tick();
    chk("byp_gone_hit", 32'(rs1_hit), 32'd0);
    chk("byp_gone_fwd", rs1_fwd, 32'd0);

    // Stream 10 ALU writes with hold toggling every 3 cycles.
    sent = 0;
    got = 0;
    pending = 0;
    for (int c = 0; c < 80 && got < 10; c++) begin
      hold = (((c / 3) % 2) == 1);
      alu_valid = (sent < 10);
      alu_rd = 5'(sent + 1);
      alu_data = 32'((sent + 1) * 256);
      settle();
      chk("wrap_ready", 32'(alu_ready), 32'(pending < 4));
      acc = alu_valid && alu_ready;
      hold_prev = hold;
      pend_pre = pending;
      tick();
      exp_pop = (pend_pre > 0) && !hold_prev;
      if (acc) sent++;
      chk("wrap_reg_wr", 32'(reg_wr), 32'(exp_pop));
      if (exp_pop) begin
        got++;
        chk("wrap_addr", 32'(wr_addr), 32'(got));
        chk("wrap_data", wr_data, 32'(got * 256));
      end
      pending = pending + int'(acc) - int'(exp_pop);
    end
    idle_inputs();
    hold = 1'b0;
    chk("wrap_all_sent", 32'(sent), 32'd10);
    tick();
    chk("wrap_final_empty", 32'(empty), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
